stg1fq: RTL and testbench
=========================

# stg1fq

Instruction fetch queue between the fetch stage (`stg1if`) and the decode stage (`stg2id`). It buffers fetched `{pc, instr}` pairs in a small circular FIFO so that a decode stall does not lose instructions already returned by instruction memory. It presents the oldest entry to decode with a valid/ready handshake, and discards all contents on a pipeline flush (branch redirect).

## Interface
- `DEPTH`, default 4: number of entries; power of two, at least 2.
- `ADDR_W`, default `` `SIZE_ADDR ``: PC width.
- `DATA_W`, default `` `SIZE_DATA ``: instruction width.

Ports:
- `iw_clk`  in  1: clock; all state changes on the rising edge.
- `iw_rst`  in  1: reset; synchronous, active-high.
- `iw_flush`  in  1: discard all entries and any same-cycle push.
- `iw_valid`  in  1: fetch presents an entry this cycle.
- `iw_pc`  in  ADDR_W: PC of the presented entry.
- `iw_instr`  in  DATA_W: instruction word of the presented entry.
- `ow_ready`  out  1: queue can accept a push this cycle; equals `!ow_full`.
- `ow_valid`  out  1: head entry is valid for decode.
- `ow_pc`  out  ADDR_W: head PC; 0 when empty.
- `ow_instr`  out  DATA_W: head instruction; 0 (NOP) when empty.
- `iw_ready`  in  1: decode accepts the head entry this cycle.
- `ow_count`  out  $clog2(DEPTH)+1: number of occupied entries.
- `ow_empty`  out  1: `ow_count == 0`.
- `ow_full`  out  1: `ow_count == DEPTH`.
- `ow_ovf`  out  1: sticky overflow flag; set when `iw_valid` is high while full, with no flush and no pop.

## Operation
- Storage: DEPTH-entry register array; write pointer `wp` and read pointer `rp` are each $clog2(DEPTH) bits, wrapping modulo DEPTH; `count` is held separately.
- Push: `push = iw_valid & (!full | pop) & !iw_flush`. Pushing into a full queue is allowed in a cycle when a pop occurs.
  - On push, the entry is written at `wp`, then `wp <= wp+1`.
  - `ow_ready` is `!full` only. The concurrent-pop allowance is internal and is not advertised on `ow_ready`.
- Pop: `pop = ow_valid & iw_ready & !iw_flush`; then `rp <= rp+1`.
- Count: `count <= count + push - pop`. Simultaneous push and pop leaves count unchanged.
- Overflow:
  - A push attempted while full with no pop is dropped and sets `ow_ovf`.
  - Array, pointers and count are unchanged in that case.
  - `ow_ovf` clears only on reset.
- Flush (priority over push and pop):
  - `wp <= 0`, `rp <= 0`, `count <= 0`.
  - The same-cycle incoming entry is dropped.
  - `ow_ovf` is kept.
- Head output:
  - `ow_valid = !empty`.
  - `ow_pc` / `ow_instr` = `array[rp]` when valid, else 0.
  - The output path is combinational from registered state only; there is no combinational path from `iw_*` to `ow_*`.
- Reset (checked before flush): pointers, count and `ow_ovf` go to 0. Array contents need not be cleared, because outputs are masked to 0 while empty.
- Reset, flush and the sticky flag are all cycle-exact. Reset mid-stream loses all entries with no partial state.

## Timing
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears on `ow_*` after edge N, i.e. in cycle N+1 when the queue was empty.
- Throughput: 1 push and 1 pop per cycle, sustained, at any occupancy.
- Decode stall: the head is held stable while `iw_ready = 0`; pushes continue until full.
- Flush asserted in cycle N: `ow_valid = 0` from cycle N+1; the first post-flush push is made in cycle N+1 at the earliest.
- Output values after reset: `ow_valid` 0, `ow_pc` 0, `ow_instr` 0, `ow_count` 0, `ow_empty` 1, `ow_full` 0, `ow_ready` 1, `ow_ovf` 0.

## Test plan
- **Reset and pass-through.** After reset, push pc 0x10 / instr 0xA5 with `iw_ready` = 1 held.
  - Next cycle: `ow_valid` = 1, `ow_pc` = 0x10, `ow_instr` = 0xA5.
  - Following cycle: empty, outputs 0.
- **Fill, stall and drain (DEPTH = 4).** Push pcs 0..5 on consecutive cycles with `iw_ready` = 0.
  - Pcs 0..3 are stored; `ow_full` = 1 and `ow_ready` = 0 after the 4th push.
  - The pc 4 push sets `ow_ovf` = 1.
  - Raising `iw_ready` drains pcs 0,1,2,3 in order over 4 cycles; `ow_ovf` stays 1.
- **Full with concurrent pop.** With the queue full and `iw_ready` = 1, push pc 9.
  - Head advances, `ow_count` stays 4, pc 9 emerges 4 pops later, `ow_ovf` stays 0.
- **Wrap-around.** Stream 20 entries with alternating `iw_ready`.
  - Output pc sequence is exactly the input sequence; `ow_count` never exceeds 4.
- **Flush priority.** With 3 entries queued, assert `iw_flush` + `iw_valid` (pc 0x40) + `iw_ready` in the same cycle.
  - Next cycle: `ow_count` = 0, `ow_valid` = 0, and pc 0x40 never appears.
  - A push in the next cycle appears one cycle later.
- **Synchronous reset mid-stream.** Pulse `iw_rst` for one cycle with 2 entries queued and `iw_valid` high.
  - All outputs return to reset values on that edge, including `ow_ovf`.
  - No reset effect is seen before the clock edge.

Source files
------------

// File: rtl/stg1fq_if.sv
// stg1fq_if: fetch-queue bus between fetch/decode (master) and the queue (slave).
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
interface stg1fq_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `SIZE_ADDR,
  parameter int DATA_W = `SIZE_DATA
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic              iw_flush;
  logic              iw_valid;
  logic [ADDR_W-1:0] iw_pc;
  logic [DATA_W-1:0] iw_instr;
  logic              iw_ready;
  logic              ow_ready;
  logic              ow_valid;
  logic [ADDR_W-1:0] ow_pc;
  logic [DATA_W-1:0] ow_instr;
  logic [CW-1:0]     ow_count;
  logic              ow_empty;
  logic              ow_full;
  logic              ow_ovf;
  modport master (
    output iw_flush, iw_valid, iw_pc, iw_instr, iw_ready,
    input  ow_ready, ow_valid, ow_pc, ow_instr, ow_count, ow_empty, ow_full, ow_ovf
  );
  modport slave (
    input  iw_flush, iw_valid, iw_pc, iw_instr, iw_ready,
    output ow_ready, ow_valid, ow_pc, ow_instr, ow_count, ow_empty, ow_full, ow_ovf
  );
endinterface

// File: rtl/stg1fq.sv
// stg1fq: circular instruction fetch queue with flush and sticky overflow.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif
module stg1fq #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = `SIZE_ADDR,
  parameter int DATA_W = `SIZE_DATA
) (
  input logic      iw_clk,
  input logic      iw_rst,
  stg1fq_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              full, empty, push, pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign pop   = !empty & q.iw_ready & !q.iw_flush;
  assign push  = q.iw_valid & (!full | pop) & !q.iw_flush;
  always_comb begin
    wp_d    = q.iw_flush ? '0 : wp_q + AW'(push);
    rp_d    = q.iw_flush ? '0 : rp_q + AW'(pop);
    count_d = q.iw_flush ? '0 : count_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q | (q.iw_valid & full & !pop & !q.iw_flush);
  end
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end
  // storage is never cleared; the head is masked to zero while empty
  always_ff @(posedge iw_clk) begin
    if (push) begin
      pc_q[wp_q]    <= q.iw_pc;
      instr_q[wp_q] <= q.iw_instr;
    end
  end
  assign q.ow_ready = !full;
  assign q.ow_valid = !empty;
  assign q.ow_pc    = empty ? '0 : pc_q[rp_q];
  assign q.ow_instr = empty ? '0 : instr_q[rp_q];
  assign q.ow_count = count_q;
  assign q.ow_empty = empty;
  assign q.ow_full  = full;
  assign q.ow_ovf   = ovf_q;
endmodule

// File: tb/tb_stg1fq.sv
// tb_stg1fq: queue-model scoreboard plus directed checks for stg1fq.
module tb_stg1fq;
  localparam int DEPTH = 4;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  logic clk = 0, rst = 1, flush = 0, valid = 0, rdy = 0;
  logic [31:0] pc = 0, instr = 0;
  int checks = 0, errors = 0, max_cnt = 0;
  bit started = 0, movf = 0;
  ent_t mq[$];
  logic [31:0] popped[$];
  always #5 clk = ~clk;
  stg1fq_if #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) bus ();
  assign bus.iw_flush = flush;
  assign bus.iw_valid = valid;
  assign bus.iw_pc    = pc;
  assign bus.iw_instr = instr;
  assign bus.iw_ready = rdy;
  stg1fq #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (.iw_clk(clk), .iw_rst(rst), .q(bus));
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, got, exp, $time);
    end
  endtask
  // reference: a plain FIFO of entries plus a sticky overflow bit
  always @(posedge clk) begin
    bit p, f;
    started = 1;
    if (rst) begin mq.delete(); movf = 0; end
    else if (flush) mq.delete();
    else begin
      p = mq.size() > 0 && rdy;
      f = mq.size() == DEPTH;
      if (valid && f && !p) movf = 1;
      if (p) begin popped.push_back(mq[0].pc); void'(mq.pop_front()); end
      if (valid && (!f || p)) mq.push_back('{pc, instr});
    end
  end
  always @(negedge clk) if (started) begin
    bit e;
    e = mq.size() == 0;
    chk("valid", bus.ow_valid, !e);
    chk("pc", bus.ow_pc, e ? 0 : mq[0].pc);
    chk("instr", bus.ow_instr, e ? 0 : mq[0].instr);
    chk("count", bus.ow_count, mq.size());
    chk("empty", bus.ow_empty, e);
    chk("full", bus.ow_full, mq.size() == DEPTH);
    chk("ready", bus.ow_ready, mq.size() != DEPTH);
    chk("ovf", bus.ow_ovf, movf);
    if (int'(bus.ow_count) > max_cnt) max_cnt = int'(bus.ow_count);
  end
  task automatic step(input logic v, input logic [31:0] p, input logic [31:0] i, input logic r, input logic fl);
    valid = v; pc = p; instr = i; rdy = r; flush = fl;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    rst = 1; step(0, 0, 0, 0, 0); rst = 0;
  endtask
  initial begin
    int n;
    do_reset();
    chk("rst_valid", bus.ow_valid, 0);
    chk("rst_pc", bus.ow_pc, 0);
    chk("rst_instr", bus.ow_instr, 0);
    chk("rst_count", bus.ow_count, 0);
    chk("rst_empty", bus.ow_empty, 1);
    chk("rst_full", bus.ow_full, 0);
    chk("rst_ready", bus.ow_ready, 1);
    chk("rst_ovf", bus.ow_ovf, 0);
    step(1, 32'h10, 32'hA5, 1, 0);
    chk("pt_valid", bus.ow_valid, 1);
    chk("pt_pc", bus.ow_pc, 32'h10);
    chk("pt_instr", bus.ow_instr, 32'hA5);
    step(0, 0, 0, 1, 0);
    chk("pt_empty", bus.ow_empty, 1);
    chk("pt_pc0", bus.ow_pc, 0);
    chk("pt_instr0", bus.ow_instr, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, i, 100 + i, 0, 0);
      if (i == 3) begin
        chk("fill_full", bus.ow_full, 1);
        chk("fill_ready", bus.ow_ready, 0);
        chk("fill_ovf0", bus.ow_ovf, 0);
      end
      if (i == 4) chk("fill_ovf1", bus.ow_ovf, 1);
    end
    chk("fill_count", bus.ow_count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", bus.ow_pc, i);
      chk("drain_instr", bus.ow_instr, 100 + i);
      step(0, 0, 0, 1, 0);
    end
    chk("drain_empty", bus.ow_empty, 1);
    chk("drain_ovf", bus.ow_ovf, 1);
    do_reset();
    chk("ovf_clr", bus.ow_ovf, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h20 + i, i, 0, 0);
    step(1, 9, 32'h99, 1, 0);
    chk("cp_count", bus.ow_count, 4);
    chk("cp_pc", bus.ow_pc, 32'h21);
    chk("cp_ovf", bus.ow_ovf, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    chk("cp_pc9", bus.ow_pc, 9);
    chk("cp_instr9", bus.ow_instr, 32'h99);
    step(0, 0, 0, 1, 0);
    chk("cp_empty", bus.ow_empty, 1);
    popped.delete();
    max_cnt = 0;
    n = 0;
    for (int c = 0; n < 20 || mq.size() > 0; c++) begin
      if (n < 20 && mq.size() < DEPTH) begin step(1, 32'h100 + n, n, c[0], 0); n++; end
      else step(0, 0, 0, c[0], 0);
    end
    chk("wrap_n", popped.size(), 20);
    for (int i = 0; i < 20 && i < popped.size(); i++) chk("wrap_seq", popped[i], 32'h100 + i);
    chk("wrap_max", max_cnt <= DEPTH, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h30 + i, i, 0, 0);
    chk("fl_pre", bus.ow_count, 3);
    step(1, 32'h40, 32'h44, 1, 1);
    chk("fl_count", bus.ow_count, 0);
    chk("fl_valid", bus.ow_valid, 0);
    step(1, 32'h50, 32'h55, 0, 0);
    chk("fl_push_pc", bus.ow_pc, 32'h50);
    chk("fl_push_count", bus.ow_count, 1);
    step(0, 0, 0, 1, 0);
    chk("fl_empty", bus.ow_empty, 1);
    for (int i = 0; i < 5; i++) step(1, 32'h60 + i, i, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("mr_count2", bus.ow_count, 2);
    chk("mr_ovf1", bus.ow_ovf, 1);
    rst = 1; valid = 1; pc = 32'h70; instr = 32'h77; rdy = 0; flush = 0;
    #3;
    chk("mr_pre_count", bus.ow_count, 2);
    chk("mr_pre_ovf", bus.ow_ovf, 1);
    @(posedge clk); #1;
    rst = 0; valid = 0;
    chk("mr_count", bus.ow_count, 0);
    chk("mr_valid", bus.ow_valid, 0);
    chk("mr_pc", bus.ow_pc, 0);
    chk("mr_ovf", bus.ow_ovf, 0);
    chk("mr_ready", bus.ow_ready, 1);
    chk("mr_empty", bus.ow_empty, 1);
    step(0, 0, 0, 0, 0);
    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
